// File: rtl/noc_perf_monitor.sv
// noc_perf_monitor
//   Passive traffic monitor for the openNocTop mesh. Watches every PE's
//   injection handshake and delivery strobe. It counts sent, received and
//   misrouted packets, plus the cycles spent in a measurement run. A run ends
//   on completion (all X*Y*numPackets packets injected and delivered) or when
//   the bus stays silent for TIMEOUT cycles (watchdog).
//
//   Handshake semantics: an injection is accepted on a cycle where both
//   r_valid_pe[i] and r_ready_pe[i] are high. A delivery is any cycle where
//   w_valid_pe[i] is high; the delivery bus has no backpressure.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           level; begins a run from IDLE or DONE
//   r_valid_pe      per-PE injection valid
//   r_ready_pe      per-PE injection ready
//   w_valid_pe      per-PE delivery valid
//   w_data_pe       delivered packets, PE i in slice i: {payload, dest_y, dest_x}
//   busy            run in progress (RUN or DRAIN)
//   done            run finished (DONE)
//   timeout         run was ended by the watchdog; meaningful while done=1
//   sent_cnt        accepted injections, saturating
//   recv_cnt        deliveries, saturating
//   misroute_cnt    deliveries whose destination is not the receiving PE
//   cycle_cnt       cycles spent in RUN+DRAIN, saturating
module noc_perf_monitor #(
    parameter int X          = 8,
    parameter int Y          = 8,
    parameter int x_size     = 3,
    parameter int y_size     = 3,
    parameter int data_width = 32,
    parameter int numPackets = 100,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [X*Y-1:0]                             r_valid_pe,
    input  logic [X*Y-1:0]                             r_ready_pe,
    input  logic [X*Y-1:0]                             w_valid_pe,
    input  logic [(x_size+y_size+data_width)*X*Y-1:0]  w_data_pe,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       timeout,
    output logic [CNT_W-1:0]                           sent_cnt,
    output logic [CNT_W-1:0]                           recv_cnt,
    output logic [CNT_W-1:0]                           misroute_cnt,
    output logic [CNT_W-1:0]                           cycle_cnt
);
    localparam int N      = X * Y;
    localparam int PKT_W  = x_size + y_size + data_width;
    localparam int PC_W   = $clog2(N + 1);
    localparam int SUM_W  = CNT_W + PC_W;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [63:0]      TOTAL   = 64'(X) * 64'(Y) * 64'(numPackets);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic              timeout_nx;
    logic [IDLE_W-1:0] idle_cnt, idle_nx;
    logic [PC_W-1:0]   pc_sent, pc_recv, pc_mis;
    logic [CNT_W-1:0]  sent_nx, recv_nx, mis_nx, cyc_nx;
    logic              active, launch, any_event, sent_full, recv_full, wd_hit;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        return s[CNT_W-1:0];
    endfunction

    // Per-cycle event popcounts across all PEs.
    always_comb begin
        logic [x_size-1:0] dx;
        logic [y_size-1:0] dy;
        pc_sent = '0;
        pc_recv = '0;
        pc_mis  = '0;
        dx      = '0;
        dy      = '0;
        for (int i = 0; i < N; i++) begin
            dx = w_data_pe[i*PKT_W +: x_size];
            dy = w_data_pe[i*PKT_W + x_size +: y_size];
            pc_sent = pc_sent + PC_W'(r_valid_pe[i] & r_ready_pe[i]);
            pc_recv = pc_recv + PC_W'(w_valid_pe[i]);
            if (w_valid_pe[i] && (int'(dy) * X + int'(dx) != i))
                pc_mis = pc_mis + PC_W'(1);
        end
    end

    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign any_event = |(r_valid_pe & r_ready_pe) || |w_valid_pe;

    assign sent_nx = sat_add(sent_cnt, pc_sent);
    assign recv_nx = sat_add(recv_cnt, pc_recv);
    assign mis_nx  = sat_add(misroute_cnt, pc_mis);
    assign cyc_nx  = sat_add(cycle_cnt, PC_W'(1));
    assign idle_nx = any_event ? '0 : idle_cnt + IDLE_W'(1);

    // Thresholds are tested on the post-update values so the state change
    // lands on the same edge as the counter that triggers it.
    assign sent_full = 64'(sent_nx) >= TOTAL;
    assign recv_full = 64'(recv_nx) >= TOTAL;
    assign wd_hit    = idle_nx >= IDLE_W'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            timeout <= timeout_nx;
        end
    end

    // Completion outranks the watchdog when both happen on one cycle.
    always_comb begin
        state_nx   = state;
        timeout_nx = timeout;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx   = S_RUN;
                    timeout_nx = 1'b0;
                end
            end
            S_RUN: begin
                if (sent_full && recv_full) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b0;
                end else if (wd_hit) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b1;
                end else if (sent_full) begin
                    state_nx   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (recv_full) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b0;
                end else if (wd_hit) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            sent_cnt     <= '0;
            recv_cnt     <= '0;
            misroute_cnt <= '0;
            cycle_cnt    <= '0;
            idle_cnt     <= '0;
        end else if (active) begin
            sent_cnt     <= sent_nx;
            recv_cnt     <= recv_nx;
            misroute_cnt <= mis_nx;
            cycle_cnt    <= cyc_nx;
            idle_cnt     <= idle_nx;
        end
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_noc_perf_monitor.sv
// Bench for noc_perf_monitor on a 2x2 mesh. The main instance sends 2 packets
// per PE (TOTAL=8) and uses TIMEOUT=16. A second instance with 4-bit counters
// exercises saturation.
module tb_noc_perf_monitor;
    localparam int X = 2, Y = 2, XS = 1, YS = 1, DW = 8, NP = 2, CW = 32, TO = 16;
    localparam int N = X * Y, PKT_W = XS + YS + DW, TOTAL = X * Y * NP;
    localparam int EXP_W = 3 + 4 * CW;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst, start, start_sat;
    logic [N-1:0] r_valid_pe, r_ready_pe, w_valid_pe;
    logic [PKT_W*N-1:0] w_data_pe;
    logic busy, done, timeout;
    logic [CW-1:0] sent_cnt, recv_cnt, misroute_cnt, cycle_cnt;
    logic s_busy, s_done, s_timeout;
    logic [3:0] s_sent, s_recv, s_mis, s_cyc;

    always #5 clk = ~clk;

    noc_perf_monitor #(.X(X), .Y(Y), .x_size(XS), .y_size(YS), .data_width(DW),
                       .numPackets(NP), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .r_valid_pe(r_valid_pe), .r_ready_pe(r_ready_pe),
        .w_valid_pe(w_valid_pe), .w_data_pe(w_data_pe),
        .busy(busy), .done(done), .timeout(timeout),
        .sent_cnt(sent_cnt), .recv_cnt(recv_cnt),
        .misroute_cnt(misroute_cnt), .cycle_cnt(cycle_cnt));

    noc_perf_monitor #(.X(X), .Y(Y), .x_size(XS), .y_size(YS), .data_width(DW),
                       .numPackets(8), .CNT_W(4), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .rst(rst), .start(start_sat),
        .r_valid_pe(r_valid_pe), .r_ready_pe(r_ready_pe),
        .w_valid_pe(w_valid_pe), .w_data_pe(w_data_pe),
        .busy(s_busy), .done(s_done), .timeout(s_timeout),
        .sent_cnt(s_sent), .recv_cnt(s_recv),
        .misroute_cnt(s_mis), .cycle_cnt(s_cyc));

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [3:0] sat_q[$];

    // reference model: 0 idle, 1 run, 2 drain, 3 done
    int     m_state = 0;
    longint m_sent = 0, m_recv = 0, m_mis = 0, m_cyc = 0;
    int     m_idle = 0;
    logic   m_to = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void model_step(input logic r, input logic st, input logic [N-1:0] rv,
                                       input logic [N-1:0] rr, input logic [N-1:0] wv,
                                       input logic [PKT_W*N-1:0] wd);
        int acc, del, mis;
        acc = 0; del = 0; mis = 0;
        if (r) begin
            m_state = 0; m_sent = 0; m_recv = 0; m_mis = 0; m_cyc = 0; m_idle = 0; m_to = 1'b0;
        end else if (m_state == 0 || m_state == 3) begin
            if (st) begin
                m_state = 1; m_sent = 0; m_recv = 0; m_mis = 0; m_cyc = 0; m_idle = 0; m_to = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rv[i] && rr[i]) acc++;
                if (wv[i]) begin
                    del++;
                    if (int'(wd[i*PKT_W + XS +: YS]) * X + int'(wd[i*PKT_W +: XS]) != i) mis++;
                end
            end
            m_sent = sat(m_sent + acc);
            m_recv = sat(m_recv + del);
            m_mis  = sat(m_mis + mis);
            m_cyc  = sat(m_cyc + 1);
            m_idle = (acc + del > 0) ? 0 : m_idle + 1;
            if ((m_state == 1 && m_sent >= TOTAL && m_recv >= TOTAL) ||
                (m_state == 2 && m_recv >= TOTAL)) begin
                m_state = 3; m_to = 1'b0;
            end else if (m_idle >= TO) begin
                m_state = 3; m_to = 1'b1;
            end else if (m_state == 1 && m_sent >= TOTAL) begin
                m_state = 2;
            end
        end
    endfunction

    function automatic logic [PKT_W*N-1:0] good_wd();
        logic [PKT_W*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i*PKT_W +: PKT_W] = {DW'($urandom), YS'(i / X), XS'(i % X)};
        return v;
    endfunction

    task automatic drive_cycle(input logic r, input logic st, input logic ss,
                               input logic [N-1:0] rv, input logic [N-1:0] rr,
                               input logic [N-1:0] wv, input logic [PKT_W*N-1:0] wd);
        logic [EXP_W-1:0] e;
        @(negedge clk);
        rst = r; start = st; start_sat = ss;
        r_valid_pe = rv; r_ready_pe = rr; w_valid_pe = wv; w_data_pe = wd;
        model_step(r, st, rv, rr, wv, wd);
        exp_q.push_back({(m_state == 1 || m_state == 2), (m_state == 3), m_to,
                         CW'(m_sent), CW'(m_recv), CW'(m_mis), CW'(m_cyc)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("busy",     64'(busy),         64'(e[EXP_W-1]));
        check("done",     64'(done),         64'(e[EXP_W-2]));
        check("timeout",  64'(timeout),      64'(e[EXP_W-3]));
        check("sent",     64'(sent_cnt),     64'(e[4*CW-1 -: CW]));
        check("recv",     64'(recv_cnt),     64'(e[3*CW-1 -: CW]));
        check("misroute", 64'(misroute_cnt), 64'(e[2*CW-1 -: CW]));
        check("cycles",   64'(cycle_cnt),    64'(e[CW-1:0]));
    endtask

    task automatic silent();
        drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, good_wd());
    endtask

    initial begin
        logic [PKT_W*N-1:0] wd;
        int idle_cycles;
        rst = 1'b1; start = 1'b0; start_sat = 1'b0;
        r_valid_pe = '0; r_ready_pe = '0; w_valid_pe = '0; w_data_pe = '0;

        // reset with random bus activity
        for (int k = 0; k < 3; k++)
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, N'($urandom_range(0, 15)),
                        N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), good_wd());
        check("rst_idle_done", 64'(done), 64'd0);
        silent();

        // clean run; traffic in the start cycle is ignored
        drive_cycle(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, good_wd());
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, good_wd());
        check("simul_sent", 64'(sent_cnt), 64'd4);
        check("simul_recv", 64'(recv_cnt), 64'd4);
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'b0011, 4'b0011, good_wd());
        silent();
        drive_cycle(1'b0, 1'b0, 1'b0, 4'b1100, 4'b1100, 4'b1100, good_wd());
        check("clean_done", 64'(done), 64'd1);
        check("clean_sent", 64'(sent_cnt), 64'd8);
        check("clean_recv", 64'(recv_cnt), 64'd8);
        check("clean_mis", 64'(misroute_cnt), 64'd0);
        check("clean_to", 64'(timeout), 64'd0);
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, good_wd());

        // restart from DONE, drain, misroute, then watchdog
        drive_cycle(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'hF, good_wd());
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_sent", 64'(sent_cnt), 64'd0);
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0, good_wd());
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0, good_wd());
        check("drain_busy", 64'(busy), 64'd1);
        wd = good_wd();
        wd[3*PKT_W +: XS+YS] = '0;
        drive_cycle(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'b1000, wd);
        check("mis_cnt", 64'(misroute_cnt), 64'd1);
        check("mis_recv", 64'(recv_cnt), 64'd1);
        drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0111, good_wd());
        drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0111, good_wd());
        idle_cycles = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            silent();
            idle_cycles++;
        end
        check("wd_cycles", 64'(idle_cycles), 64'd16);
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_recv", 64'(recv_cnt), 64'd7);

        // reset in the middle of a run
        drive_cycle(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, good_wd());
        drive_cycle(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'h3, good_wd());
        drive_cycle(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, good_wd());
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sent", 64'(sent_cnt), 64'd0);

        // saturation on the 4-bit instance: 20 deliveries, recv holds at 15
        sat_q.push_back(4'd0);
        drive_cycle(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'hF, good_wd());
        check("sat_recv", 64'(s_recv), 64'(sat_q.pop_front()));
        for (int k = 1; k <= 7; k++) begin
            sat_q.push_back((k * 4 > 15) ? 4'd15 : 4'(k * 4));
            drive_cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, (k <= 5) ? 4'hF : 4'h0, good_wd());
            check("sat_recv", 64'(s_recv), 64'(sat_q.pop_front()));
            if (k == 6) sat_q.push_back(4'd0);
            if (k == 6) sat_q.pop_front();
        end
        check("sat_busy", 64'(s_busy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
